clz_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for the CLZ/CLO instructions of the 54-instruction CPU.

---
 rtl/clz_seq_ctrl_if.sv | 34 +++
 rtl/clz_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_clz_seq_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/clz_seq_ctrl_if.sv
// Request/response bundle between the CPU execute stage and the CLZ/CLO sequencer.
//   start  : operation request, held by the CPU until done is seen
//   op     : 0 = CLZ, 1 = CLO (sampled with start)
//   data   : 32-bit operand rs (sampled with start)
//   busy   : sequencer is scanning; CPU stalls PC/IR and suppresses write-back
//   done   : one-cycle pulse, result valid for rd write-back
//   result : leading-bit count 0..32, zero-extended
// master = CPU side, slave = sequencer side.
interface clz_seq_ctrl_if;
    logic        start;
    logic        op;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output op,
        output data,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  data,
        output busy,
        output done,
        output result
    );
endinterface : clz_seq_ctrl_if

// File: rtl/clz_seq_ctrl.sv
// Multi-cycle CLZ/CLO sequencer. Scans the operand one CHUNK_W-bit slice per
// cycle, MSB slice first, and stops at the first nonzero slice. CLO is done by
// inverting the operand at acceptance, so the scan path is shared.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything (scan discarded)
//   bus : clz_seq_ctrl_if.slave (start/op/data in, busy/done/result out)
// CHUNK_W must be one of 4, 8, 16, 32.
module clz_seq_ctrl #(
    parameter int unsigned CHUNK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    clz_seq_ctrl_if.slave     bus
);

    localparam int unsigned NCHUNK = 32 / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CNT_W  = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_opnd;
    logic [31:0]        w_opnd_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [CNT_W-1:0]   r_result;
    logic [CNT_W-1:0]   w_result_nxt;
    logic               r_busy;
    logic               r_done;
    logic [CHUNK_W-1:0] w_slice;
    logic [CNT_W-1:0]   w_lz;

    // Leading zeros within one slice; an all-zero slice never reaches here.
    function automatic logic [CNT_W-1:0] lz_slice(input logic [CHUNK_W-1:0] s);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = int'(CHUNK_W) - 1; i >= 0; i--) begin
            if (!found) begin
                if (s[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + CNT_W'(1);
                end
            end
        end
        return n;
    endfunction

    // Slice select by current index (constant-offset mux, no variable shift).
    always_comb begin
        w_slice = '0;
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            if (r_idx == IDX_W'(c)) begin
                w_slice = r_opnd[c*CHUNK_W +: CHUNK_W];
            end
        end
    end

    assign w_lz = lz_slice(w_slice);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_opnd   <= w_opnd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_result <= w_result_nxt;
            r_busy   <= (w_state_nxt == S_SCAN);
            r_done   <= (w_state_nxt == S_DONE);
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        w_state_nxt  = r_state;
        w_opnd_nxt   = r_opnd;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_result_nxt = r_result;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_opnd_nxt  = bus.op ? ~bus.data : bus.data;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_W'(NCHUNK - 1);
                    w_state_nxt = S_SCAN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (w_slice != '0) begin
                    w_result_nxt = r_cnt + w_lz;
                    w_state_nxt  = S_DONE;
                end else if (r_idx == '0) begin
                    // Every slice was zero: full-width count.
                    w_result_nxt = CNT_W'(32);
                    w_state_nxt  = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(CHUNK_W);
                    w_idx_nxt = r_idx - IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = 32'(r_result);

endmodule : clz_seq_ctrl

// File: tb/tb_clz_seq_ctrl.sv
// Bench for clz_seq_ctrl: four instances (CHUNK_W 4/8/16/32) share one stimulus.
// Directed timing cases use the CHUNK_W=8 instance; sweeps check all widths.
module tb_clz_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clz_seq_ctrl_if if4 ();
    clz_seq_ctrl_if if8 ();
    clz_seq_ctrl_if if16 ();
    clz_seq_ctrl_if if32 ();

    assign if4.start  = start;
    assign if4.op     = op;
    assign if4.data   = data;
    assign if8.start  = start;
    assign if8.op     = op;
    assign if8.data   = data;
    assign if16.start = start;
    assign if16.op    = op;
    assign if16.data  = data;
    assign if32.start = start;
    assign if32.op    = op;
    assign if32.data  = data;

    clz_seq_ctrl #(.CHUNK_W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
    clz_seq_ctrl #(.CHUNK_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    clz_seq_ctrl #(.CHUNK_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
    clz_seq_ctrl #(.CHUNK_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Golden count: position of the first 1 from the MSB of the (possibly inverted) operand.
    function automatic int clz_ref(input logic o, input logic [31:0] d);
        logic [31:0] v;
        v = o ? ~d : d;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 31 - i;
        end
        return 32;
    endfunction

    // Negedges from the start drive to done: one per SCAN cycle plus one.
    function automatic int lat_ref(input int n, input int w);
        if (n == 32) return 32 / w + 1;
        return n / w + 2;
    endfunction

    // Launch one op on all instances (all must be idle) and check each width.
    task automatic sweep(input logic o, input logic [31:0] d, input string tag);
        int          lat[4];
        int          npulse[4];
        logic [31:0] res[4];
        logic        dn[4];
        logic [31:0] rs[4];
        int          wid[4];
        int          n;
        wid = '{4, 8, 16, 32};
        for (int i = 0; i < 4; i++) begin
            lat[i]    = -1;
            npulse[i] = 0;
            res[i]    = 32'hDEAD_BEEF;
        end
        start = 1'b1;
        op    = o;
        data  = d;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0;
                data  = $urandom;
                op    = ~o;
            end
            dn[0] = if4.done;  rs[0] = if4.result;
            dn[1] = if8.done;  rs[1] = if8.result;
            dn[2] = if16.done; rs[2] = if16.result;
            dn[3] = if32.done; rs[3] = if32.result;
            for (int i = 0; i < 4; i++) begin
                if (dn[i]) begin
                    npulse[i]++;
                    if (lat[i] < 0) begin
                        lat[i] = j;
                        res[i] = rs[i];
                    end
                end
            end
        end
        n = clz_ref(o, d);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_w%0d_lat", tag, wid[i]), 32'(lat[i]), 32'(lat_ref(n, wid[i])));
            chk($sformatf("%s_w%0d_res", tag, wid[i]), res[i], 32'(n));
            chk($sformatf("%s_w%0d_pulses", tag, wid[i]), 32'(npulse[i]), 32'd1);
        end
    endtask

    initial begin
        int          j;
        int          ndone;
        logic [31:0] d;

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(if8.busy), 32'd0);
        chk("rst_done", 32'(if8.done), 32'd0);
        chk("rst_result", if8.result, 32'd0);
        chk("rst_result_w4", if4.result, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Minimum latency: busy for one cycle, done on the next.
        start = 1'b1; op = 1'b0; data = 32'h8000_0000;
        @(negedge clk);
        start = 1'b0;
        chk("min_busy1", 32'(if8.busy), 32'd1);
        chk("min_done1", 32'(if8.done), 32'd0);
        @(negedge clk);
        chk("min_busy2", 32'(if8.busy), 32'd0);
        chk("min_done2", 32'(if8.done), 32'd1);
        chk("min_result", if8.result, 32'd0);
        @(negedge clk);
        chk("min_done_pulse", 32'(if8.done), 32'd0);
        repeat (10) @(negedge clk);

        // Directed cases across all widths.
        sweep(1'b0, 32'h8000_0000, "clz_msb");
        sweep(1'b0, 32'h0000_0001, "clz_lsb");
        sweep(1'b0, 32'h0000_0000, "clz_zero");
        sweep(1'b1, 32'hFFFF_FFFF, "clo_ones");
        sweep(1'b1, 32'hFFF0_1234, "clo_12");
        sweep(1'b0, 32'h0000_8000, "clz_16");

        // Back-to-back: start held through done.
        start = 1'b1; op = 1'b0; data = 32'h0040_0000;
        j = 0;
        while (j < 12 && if8.done !== 1'b1) begin
            @(negedge clk);
            j++;
        end
        chk("b2b_first_lat", 32'(j), 32'd3);
        chk("b2b_first_res", if8.result, 32'd9);
        data = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_rescan_busy", 32'(if8.busy), 32'd1);
        chk("b2b_hold_res", if8.result, 32'd9);
        j = 1;
        while (j < 12 && if8.done !== 1'b1) begin
            chk("b2b_hold_res_loop", if8.result, 32'd9);
            @(negedge clk);
            j++;
        end
        chk("b2b_second_lat", 32'(j), 32'd4);
        chk("b2b_second_res", if8.result, 32'd16);
        repeat (12) @(negedge clk);

        // Reset in the second SCAN cycle discards the scan.
        chk("pre_rst_res", if8.result, 32'd16);
        start = 1'b1; op = 1'b0; data = 32'h0;
        @(negedge clk);
        start = 1'b0;
        chk("rst_scan1_busy", 32'(if8.busy), 32'd1);
        @(negedge clk);
        chk("rst_scan2_busy", 32'(if8.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(if8.busy), 32'd0);
        chk("midrst_done", 32'(if8.done), 32'd0);
        chk("midrst_result", if8.result, 32'd0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if8.done === 1'b1) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        chk("midrst_result_hold", if8.result, 32'd0);

        // Start pulsed during SCAN with different operand is ignored.
        start = 1'b1; op = 1'b0; data = 32'h0000_0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; data = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; op = 1'b0; data = 32'h1234_5678;
        j = 3;
        while (j < 14 && if8.done !== 1'b1) begin
            @(negedge clk);
            j++;
        end
        chk("ign_lat", 32'(j), 32'd5);
        chk("ign_res", if8.result, 32'd31);
        @(negedge clk);
        chk("ign_no_relaunch", 32'(if8.busy), 32'd0);
        repeat (12) @(negedge clk);

        // One-hot and zero operands, CLZ and CLO.
        for (int b = 0; b <= 32; b++) begin
            d = (b == 32) ? 32'h0 : (32'h1 << b);
            sweep(1'b0, d, $sformatf("oh_clz_b%0d", b));
            sweep(1'b1, ~d, $sformatf("oh_clo_b%0d", b));
        end

        // Random operands with a spread of leading-bit counts.
        for (int r = 0; r < 150; r++) begin
            logic o;
            o = 1'($urandom_range(0, 1));
            d = $urandom >> $urandom_range(0, 32);
            if (o) d = ~d;
            sweep(o, d, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clz_seq_ctrl
